status_serializer: RTL and testbench
====================================

// Module: status_serializer
// PURPOSE
// - Uplink transmitter for object status. Runs in the object clock domain, watches the
//   N_OBJ-bit status vector from the object array, and reports each changed bit as a
//   serial frame {address, value}.
// - Uses the same busy/ser_data line protocol as the command downlink, so the existing
//   deserializer decodes its frames unmodified.
// PARAMETERS
// - N_OBJ       18  number of status bits; object k (1-based) owns status_i[k-1]
// - ADDR_W      5   frame address width; require N_OBJ <= 2**ADDR_W-1 (elab $error otherwise)
// - GAP_CYCLES  1   idle cycles (busy_o low) forced after every frame; require >= 1
// PORTS
// - clk_i       in   1       single clock (object domain)
// - rst_i       in   1       asynchronous, active-low reset
// - status_i    in   N_OBJ   live object status vector
// - refresh_i   in   1       1-cycle pulse: re-report all N_OBJ bits regardless of change
// - ser_data_o  out  1       serial frame data, MSB first
// - busy_o      out  1       high exactly while frame bits are on ser_data_o
// - pending_o   out  1       at least one bit awaiting report
// BEHAVIOUR
// - Reset (async, rst_i=0): busy_o=0, ser_data_o=0, shadow=0, refresh mask=0, rr_ptr=0,
//   FSM=IDLE. All outputs take reset values immediately. An in-flight frame is dropped;
//   no partial-frame completion.
// - Pending vector: pend = (status_i ^ shadow) | refresh_mask. pending_o = |pend (comb).
// - refresh_i: sets refresh_mask to all ones. Each mask bit clears when its frame loads.
//   refresh_i during a frame is honoured; the in-flight bit is re-sent.
// - Selection: round-robin. Choose the lowest pending index i >= rr_ptr; if none,
//   wrap to the lowest pending index overall. After a load, rr_ptr = (i+1) mod N_OBJ.
// - FSM: IDLE -> SHIFT -> GAP -> IDLE.
//   - IDLE, at an edge with |pend: load shift_reg = {ADDR_W'(i+1), status_i[i]}.
//     Set shadow[i] = status_i[i] and clear refresh_mask[i].
//     On that same edge: busy_o<=1, ser_data_o<=frame MSB, go to SHIFT.
//   - SHIFT: each edge presents the next bit. Each bit is held exactly one cycle.
//     Frame length FL = ADDR_W+1 (6 by default) cycles of busy_o=1.
//   - After the last bit: busy_o<=0, ser_data_o<=0. GAP lasts GAP_CYCLES, then IDLE.
// - Latency: a status change visible before edge E (FSM in IDLE) gives busy_o=1 after E.
//   Minimum frame-to-frame spacing is FL+GAP_CYCLES (7 default).
// - The value sent is status_i sampled at load. Changes during SHIFT/GAP do not alter the
//   current frame.
// - Change-back filter: a bit that toggles and returns before its load is not reported.
//   A bit that changes again after its load is reported again.
// - Simultaneous change of many bits: one frame per bit, in round-robin order. No loss.
//   The shadow compare guarantees the final state is eventually reported.
// CONFIGURATION
// - STATUS_SER_PARITY_EN defined:
//   - Append an even-parity bit after the value bit, over the address and value bits.
//   - FL = ADDR_W+2 (7 default); busy_o stays high for that bit.
//   - The receiver must be built with matching parity support.
// - Macro undefined: no parity bit, FL = ADDR_W+1. Everything else is identical.
// TESTING
// - Reset, status_i=0, no refresh -> busy_o stays 0 and pending_o=0 for 100 cycles.
// - status_i[2] 0->1 -> next edge busy_o=1; ser_data_o = 0,0,0,1,1,1 (addr 3, val 1)
//   over 6 cycles; then busy_o=0 for 1 cycle; pending_o=0 afterwards.
// - status_i[0] and status_i[17] rise on the same edge, rr_ptr=0 -> frame addr 1/val 1,
//   then frame addr 18/val 1, with busy_o rising edges 7 cycles apart.
// - refresh_i pulse, status_i=18'h00005 -> 18 frames, addr 1..18.
//   Values: 1 for addr 1 and 3, 0 for all others. No duplicates; pending_o=0 at end.
// - During a frame for bit 4, status_i[9] pulses 1 for 2 cycles and returns to 0
//   -> no frame for addr 10 is ever sent.
// - rst_i driven low in the 3rd bit of a frame -> busy_o=0 and ser_data_o=0 with no
//   clock edge needed. After release with status_i[5]=1 -> a full frame for addr 6/val 1.
// - STATUS_SER_PARITY_EN: status_i[2] rise -> 0,0,0,1,1,1,1 (parity=1, 3 ones in
//   payload) with busy_o high for 7 cycles.

Source files
------------

// File: rtl/status_serializer.sv
// ============================================================================
// Module   : status_serializer
// Purpose  : Uplink transmitter for object status. Compares the live status
//            vector against a shadow copy and sends each changed bit as a
//            serial frame {address, value[, parity]} on the busy/ser_data
//            line protocol shared with the command downlink.
// Options  : define STATUS_SER_PARITY_EN to append an even-parity bit over
//            the address and value bits (frame length ADDR_W+2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_serializer #(
    parameter int N_OBJ      = 18,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_OBJ-1:0] status_i,
    input  logic             refresh_i,
    output logic             ser_data_o,
    output logic             busy_o,
    output logic             pending_o
);

`ifdef STATUS_SER_PARITY_EN
    localparam int FL = ADDR_W + 2;
`else
    localparam int FL = ADDR_W + 1;
`endif
    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int CNT_W = $clog2(FL + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Address 0 is reserved, so objects occupy addresses 1..N_OBJ.
    generate
        if (N_OBJ > (2 ** ADDR_W) - 1) begin : g_bad_n_obj
            $error("status_serializer: N_OBJ does not fit in ADDR_W address bits");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("status_serializer: GAP_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               load;

    logic [N_OBJ-1:0]   shadow;
    logic [N_OBJ-1:0]   refresh_mask;
    logic [N_OBJ-1:0]   pend;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_idx_hi;
    logic [IDX_W-1:0]   sel_idx_any;
    logic               sel_found_hi;

    logic [FL-1:0]      shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_bit;
    logic               gap_done;

    logic [ADDR_W-1:0]  frame_addr;
    logic               frame_val;
    logic [FL-1:0]      frame;

    // A bit is pending when it differs from what was last reported, or a
    // refresh has asked for it again.
    assign pend      = (status_i ^ shadow) | refresh_mask;
    assign pending_o = |pend;

    // Round-robin pick: lowest pending index at or above rr_ptr, else wrap
    // to the lowest pending index overall.
    always_comb begin
        sel_found_hi = 1'b0;
        sel_idx_hi   = '0;
        sel_idx_any  = '0;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (pend[k]) begin
                sel_idx_any = IDX_W'(k);
                if (IDX_W'(k) >= rr_ptr) begin
                    sel_idx_hi   = IDX_W'(k);
                    sel_found_hi = 1'b1;
                end
            end
        end
        sel_idx = sel_found_hi ? sel_idx_hi : sel_idx_any;
    end

    assign rr_next    = (sel_idx == IDX_W'(N_OBJ - 1)) ? '0 : sel_idx + IDX_W'(1);
    assign frame_addr = ADDR_W'(sel_idx) + ADDR_W'(1);
    assign frame_val  = status_i[sel_idx];
`ifdef STATUS_SER_PARITY_EN
    assign frame      = {frame_addr, frame_val, ^{frame_addr, frame_val}};
`else
    assign frame      = {frame_addr, frame_val};
`endif

    assign last_bit = (bit_cnt == CNT_W'(FL));
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load strobe; the final gap cycle may start the next
    // frame directly so back-to-back frames are spaced FL+GAP_CYCLES apart.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pending_o) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (pending_o) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath, shadow/refresh bookkeeping and registered line outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow       <= '0;
            refresh_mask <= '0;
            rr_ptr       <= '0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            busy_o       <= 1'b0;
            ser_data_o   <= 1'b0;
        end else begin
            if (load) begin
                shift_reg             <= {frame[FL-2:0], 1'b0};
                ser_data_o            <= frame[FL-1];
                busy_o                <= 1'b1;
                bit_cnt               <= CNT_W'(1);
                shadow[sel_idx]       <= frame_val;
                refresh_mask[sel_idx] <= 1'b0;
                rr_ptr                <= rr_next;
            end else if (state == SHIFT) begin
                if (last_bit) begin
                    busy_o     <= 1'b0;
                    ser_data_o <= 1'b0;
                    gap_cnt    <= '0;
                end else begin
                    ser_data_o <= shift_reg[FL-1];
                    shift_reg  <= {shift_reg[FL-2:0], 1'b0};
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            // A refresh wins over the clear of a bit loading on the same edge,
            // so that bit is sent again.
            if (refresh_i) begin
                refresh_mask <= '1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_status_serializer.sv
`default_nettype none

module tb_status_serializer;

    localparam int N_OBJ  = 18;
    localparam int ADDR_W = 5;
`ifdef STATUS_SER_PARITY_EN
    localparam int FL = ADDR_W + 2;
    localparam logic [FL-1:0] FRAME_A3_V1 = 7'b0001111;
`else
    localparam int FL = ADDR_W + 1;
    localparam logic [FL-1:0] FRAME_A3_V1 = 6'b000111;
`endif

    logic             clk_i;
    logic             rst_i;
    logic [N_OBJ-1:0] status_i;
    logic             refresh_i;
    logic             ser_data_o;
    logic             busy_o;
    logic             pending_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    status_serializer #(
        .N_OBJ      (N_OBJ),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (1)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .status_i   (status_i),
        .refresh_i  (refresh_i),
        .ser_data_o (ser_data_o),
        .busy_o     (busy_o),
        .pending_o  (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FL-1:0] mk(input int a, input logic v);
        logic [ADDR_W-1:0] ad;
        ad = ADDR_W'(a);
`ifdef STATUS_SER_PARITY_EN
        return {ad, v, ^{ad, v}};
`else
        return {ad, v};
`endif
    endfunction

    // Waits (bounded) for busy, collects FL bits, checks bits, busy length
    // and the idle line afterwards. 'pulse' is toggled on status_i after the
    // first bit and toggled back after the third.
    task automatic expect_frame(input string tag, input logic [FL-1:0] exp_f,
                                input int budget, input logic [N_OBJ-1:0] pulse,
                                output int rise);
        logic [FL-1:0] got;
        int w;
        int hi;
        w = 0;
        do begin
            tick();
            w++;
        end while (!busy_o && w < budget);
        check({tag, " start"}, 32'(busy_o), 32'd1);
        rise = cyc;
        got  = '0;
        hi   = 0;
        for (int b = 0; b < FL; b++) begin
            got = {got[FL-2:0], ser_data_o};
            if (busy_o) hi++;
            if (b == 0 || b == 2) status_i = status_i ^ pulse;
            tick();
        end
        check({tag, " bits"}, 32'(got), 32'(exp_f));
        check({tag, " busylen"}, 32'(hi), 32'(FL));
        check({tag, " end"}, {30'd0, busy_o, ser_data_o}, 32'd0);
    endtask

    initial begin
        int r1, r2, rdum;
        logic bad_busy, bad_pend;

        rst_i     = 1'b0;
        status_i  = '0;
        refresh_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst ser", 32'(ser_data_o), 32'd0);
        check("rst pend", 32'(pending_o), 32'd0);
        rst_i = 1'b1;

        // Quiet for 100 cycles with no change
        bad_busy = 1'b0;
        bad_pend = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (busy_o) bad_busy = 1'b1;
            if (pending_o) bad_pend = 1'b1;
        end
        check("idle busy", 32'(bad_busy), 32'd0);
        check("idle pend", 32'(bad_pend), 32'd0);

        // Single change of bit 2: addr 3, value 1, one-edge latency
        status_i[2] = 1'b1;
        #1;
        check("a3 pend", 32'(pending_o), 32'd1);
        expect_frame("a3", FRAME_A3_V1, 1, '0, rdum);
        check("a3 pend after", 32'(pending_o), 32'd0);
        tick();
        check("a3 quiet", 32'(busy_o), 32'd0);

        // Fresh reset, then bits 0 and 17 together: addr 1 then addr 18
        rst_i    = 1'b0;
        status_i = '0;
        tick();
        rst_i = 1'b1;
        tick();
        status_i = 18'h20001;
        expect_frame("a1", mk(1, 1'b1), 1, '0, r1);
        expect_frame("a18", mk(18, 1'b1), 3, '0, r2);
        check("a1-a18 spacing", 32'(r2 - r1), 32'(FL + 1));
        check("a18 pend after", 32'(pending_o), 32'd0);

        // Refresh, then status 0x00005: 18 frames in address order
        refresh_i = 1'b1;
        tick();
        refresh_i = 1'b0;
        status_i  = 18'h00005;
        #1;
        check("refresh pend", 32'(pending_o), 32'd1);
        for (int k = 1; k <= N_OBJ; k++) begin
            expect_frame($sformatf("rf%0d", k), mk(k, (k == 1 || k == 3)), 2, '0, rdum);
        end
        check("refresh pend after", 32'(pending_o), 32'd0);
        tick();
        check("refresh quiet", 32'(busy_o), 32'd0);

        // Frame for bit 4 while bit 9 pulses high for two cycles
        status_i[4] = 1'b1;
        expect_frame("a5", mk(5, 1'b1), 1, 18'h00200, rdum);
        check("glitch status restored", 32'(status_i), 32'h00015);
        bad_busy = 1'b0;
        bad_pend = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (busy_o) bad_busy = 1'b1;
            if (pending_o) bad_pend = 1'b1;
        end
        check("glitch no frame", 32'(bad_busy), 32'd0);
        check("glitch no pend", 32'(bad_pend), 32'd0);

        // Reset in the 3rd bit of the addr-4 frame (bits 0,0,1,...)
        status_i[3] = 1'b1;
        tick();
        check("a4 bit1", {30'd0, busy_o, ser_data_o}, 32'd2);
        tick();
        check("a4 bit2", {30'd0, busy_o, ser_data_o}, 32'd2);
        tick();
        check("a4 bit3", {30'd0, busy_o, ser_data_o}, 32'd3);
        rst_i = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst ser", 32'(ser_data_o), 32'd0);
        status_i = 18'h00020;
        tick();
        check("held rst busy", 32'(busy_o), 32'd0);
        rst_i = 1'b1;
        expect_frame("a6", mk(6, 1'b1), 2, '0, rdum);
        check("a6 pend after", 32'(pending_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
